icache_responder: RTL
=====================

Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache. It is the responder on the instruction half of the datapath–cache interface.
- Datapath side: it accepts imemREN/imemaddr from the pipelined datapath and returns ihit/imemload.
- Memory side: on a miss it issues a single-word fill request to the memory controller (iREN/iaddr, completion on iwait low) and installs the returned word.
- Sits between the datapath's IF stage and the memory arbiter. It keeps a hit counter for performance reporting.

Parameters:
- NSETS, 16, number of frames; power of two, at least 2.
- IDX_W, 4, index width; equals log2(NSETS).
- TAG_W, 26, tag width; equals 32-IDX_W-2.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  datapath instruction read request
- imemaddr  input  32  datapath instruction byte address; bits [1:0] ignored
- ihit  output  1  imemload valid this cycle for imemaddr
- imemload  output  32  instruction word
- iREN  output  1  fill request to memory controller
- iaddr  output  32  fill word address, bits [1:0] = 0
- iwait  input  1  memory busy; low = iload valid and fill done
- iload  input  32  fill data from memory
- hit_count  output  32  number of cycles with ihit=1 since reset

Behaviour:
- Clock and reset:
  - One clock (CLK). Asynchronous active-low reset (nRST).
  - Reset clears every valid bit, state=IDLE, hit_count=0.
  - Output values during reset: ihit=0, iREN=0, iaddr=0, imemload=0.
- Address split: tag=imemaddr[31:IDX_W+2], idx=imemaddr[IDX_W+1:2].
- Frame: valid bit, tag, 32-bit data. Storage is flops; tag and data are not reset.
- State IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==tag).
  - hit is combinational, zero latency: ihit=hit, imemload=data[idx] in the same cycle.
  - When ihit=0, imemload is driven with data[idx], don't-care for checking.
  - hit_count increments on every clock where ihit=1 and wraps at 2^32.
  - Miss (imemREN & ~hit): latch miss_addr = {imemaddr[31:2],2'b00}; next state FETCH. ihit=0 this cycle.
  - imemREN=0: no action, ihit=0.
- State FETCH:
  - iREN=1, iaddr=miss_addr. ihit=0 regardless of imemaddr, including addresses that would hit.
  - iwait=1: remain in FETCH.
  - iwait=0: write data[miss_idx]=iload, tag[miss_idx]=miss_tag, valid=1; next state IDLE.
  - Fill latency is 1 + memory wait cycles. The refetch hits on the first IDLE cycle after the fill.
- Mid-fetch changes:
  - A fill in progress always completes, even if imemREN drops or imemaddr changes (branch flush, halt). The memory controller never sees iREN withdrawn before completion.
  - After return to IDLE, the current imemaddr is re-evaluated normally.
- Replacement: a fill overwrites whatever occupies the frame (conflict eviction); there is no dirty state.
- Reset mid-FETCH: state returns to IDLE, iREN drops immediately and asynchronously, and the partial fill is discarded.
- iREN is only ever asserted in FETCH.
- iwait=0 observed in IDLE is ignored.

Decomposition:
- Shared package: icache_frame_t {valid, tag[TAG_W], data word_t}; icache_state_t enum {IDLE, FETCH}; address-split struct icachef_t {tag, idx, bytoff}.
- Reuse word_t from the cpu types package.
- One sub-module, icache_frames: register array with a read port (idx → frame) and a write port (wen, idx, frame), with async clear of valid bits.
- The top level holds the FSM, miss latch and counter.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0000; memory holds 0x2001_0005 with iwait=1 for 2 cycles, then 0 → ihit=0 for 4 cycles, iREN=1 with iaddr=0x0 for 3 cycles, then ihit=1 with imemload=0x2001_0005 in cycle 5, and hit_count=1 after that edge.
- Hold imemaddr=0x0000_0000 for 10 cycles after the fill → ihit=1 every cycle, iREN=0, hit_count=10.
- Conflict: fill 0x0000_0004, then access 0x0000_0044 (same idx=1, tag differs) → miss, fill with iaddr=0x44. A return to 0x04 misses again.
- Address changes to 0x0000_0100 while FETCH is waiting on 0x08 → fill of 0x08 completes. The next IDLE cycle misses on 0x100 and the next iaddr=0x100. A later access to 0x08 hits.
- imemaddr=0x0000_000B → treated as word 0x08; iaddr=0x0000_0008.
- nRST pulsed low during FETCH → iREN=0 immediately; after release, the previously filled 0x00 misses (all valid bits cleared), and hit_count=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types used across the CPU and its caches.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/icache_responder_pkg.sv
// Instruction-cache types: frame layout, FSM states and address split.
package icache_responder_pkg;

  import cpu_types_pkg::*;

  localparam int unsigned ICACHE_NSETS = 16;
  localparam int unsigned ICACHE_IDX_W = 4;
  localparam int unsigned ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

  // One direct-mapped frame.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Byte address viewed as tag / index / byte offset.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  // Word-align a byte address.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_frames.sv
// Frame storage: flop array with one combinational read port and one write port.
// Only the valid bits are reset; tag and data hold whatever was last written.
module icache_frames
  import cpu_types_pkg::*;
  import icache_responder_pkg::*;
#(
  parameter int unsigned NSETS = ICACHE_NSETS,
  parameter int unsigned IDX_W = ICACHE_IDX_W
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [IDX_W-1:0] ridx,
  output icache_frame_t rframe,
  input  logic          wen,
  input  logic [IDX_W-1:0] widx,
  input  icache_frame_t wframe
);

  logic [NSETS-1:0]        valid_q;
  logic [ICACHE_TAG_W-1:0] tag_q  [NSETS];
  word_t                   data_q [NSETS];

  // Valid bits: cleared asynchronously so a reset invalidates the whole cache.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (wen) begin
      valid_q[widx] <= wframe.valid;
    end
  end

  // Tag and data payload, written on fill only.
  always_ff @(posedge CLK) begin
    if (wen) begin
      tag_q[widx]  <= wframe.tag;
      data_q[widx] <= wframe.data;
    end
  end

  // Combinational read of the indexed frame.
  always_comb begin
    rframe.valid = valid_q[ridx];
    rframe.tag   = tag_q[ridx];
    rframe.data  = data_q[ridx];
  end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache with single-word blocking fills
// and a hit counter.
module icache_responder
  import cpu_types_pkg::*;
  import icache_responder_pkg::*;
#(
  parameter int unsigned NSETS = ICACHE_NSETS,
  parameter int unsigned IDX_W = ICACHE_IDX_W,
  parameter int unsigned TAG_W = ICACHE_TAG_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count
);

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  word_t         hit_count_q, hit_count_d;

  icachef_t      req_f;
  icachef_t      miss_f;
  icache_frame_t rframe;
  icache_frame_t wframe;
  logic          wen;
  logic          hit;
  logic          unused_bytoff;

  assign req_f         = icachef_t'(imemaddr);
  assign miss_f        = icachef_t'(miss_addr_q);
  // Instruction fetches are word-granular; the byte offset never matters.
  assign unused_bytoff = ^req_f.bytoff ^ ^miss_f.bytoff;

  icache_frames #(
    .NSETS (NSETS),
    .IDX_W (IDX_W)
  ) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .ridx   (req_f.idx),
    .rframe (rframe),
    .wen    (wen),
    .widx   (miss_f.idx),
    .wframe (wframe)
  );

  // FSM state, miss address latch and hit counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_count_q <= hit_count_d;
    end
  end

  // Lookup, miss handling and fill sequencing.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    wen         = 1'b0;
    wframe      = '{valid: 1'b1, tag: miss_f.tag, data: iload};
    hit         = 1'b0;
    iREN        = 1'b0;
    iaddr       = '0;

    unique case (state_q)
      IDLE: begin
        hit = imemREN & rframe.valid & (rframe.tag == req_f.tag);
        if (imemREN && !hit) begin
          miss_addr_d = word_align(imemaddr);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Once started, a fill always runs to completion regardless of the request.
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          wen     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hit_count_d = hit ? hit_count_q + 32'd1 : hit_count_q;
  end

  assign ihit      = hit;
  // Gating with valid keeps imemload at zero while the cache is invalidated.
  assign imemload  = rframe.valid ? rframe.data : '0;
  assign hit_count = hit_count_q;

endmodule
